// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the ecap5 processor front end.
package ecap5_dproc_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] BOOT_ADDRESS      = 32'h0000_0000;
    localparam logic [XLEN-1:0] INTERRUPT_ADDRESS = 32'hFF00_000A;
    localparam logic [XLEN-1:0] DEBUG_ADDRESS     = 32'hFF00_000B;

    localparam logic [XLEN-1:0] PC_INCREMENT = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_OUT   = 2'd2,
        S_FLUSH = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Non-pipelined instruction fetch controller: owns the PC, issues one fetch at a
// time and hands each instruction to decode, dropping responses made stale by redirects.
module fetch_sequencer
    import ecap5_dproc_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR = BOOT_ADDRESS,
    parameter logic [XLEN-1:0] IRQ_ADDR  = INTERRUPT_ADDRESS,
    parameter logic [XLEN-1:0] DBG_ADDR  = DEBUG_ADDRESS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            irq_i,
    input  logic            drq_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            stall_i,
    output logic            if_req_o,
    output logic [XLEN-1:0] if_addr_o,
    input  logic            if_ack_i,
    input  logic [XLEN-1:0] if_data_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_q, pending_d;
    logic [XLEN-1:0] instr_d, pc_out_d;
    logic            redirect_c;
    logic [XLEN-1:0] target_c;

    // Redirect source priority: debug over interrupt over branch.
    always_comb begin
        redirect_c = drq_i | irq_i | branch_i;
        if (drq_i) begin
            target_c = DBG_ADDR;
        end else if (irq_i) begin
            target_c = IRQ_ADDR;
        end else begin
            target_c = branch_target_i;
        end
    end

    // Next-state, PC and presented-instruction selection.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        instr_d   = instr_o;
        pc_out_d  = pc_o;
        unique case (state_q)
            S_IDLE: begin
                if (redirect_c) begin
                    pc_d = target_c;
                end
                state_d = S_REQ;
            end
            S_REQ: begin
                if (if_ack_i) begin
                    if (redirect_c) begin
                        pc_d = target_c;
                    end else begin
                        instr_d  = if_data_i;
                        pc_out_d = pc_q;
                        state_d  = S_OUT;
                    end
                end else if (redirect_c) begin
                    // Keep the in-flight request stable; retarget once it completes.
                    pending_d = target_c;
                    state_d   = S_FLUSH;
                end
            end
            S_OUT: begin
                if (redirect_c) begin
                    pc_d    = target_c;
                    state_d = S_REQ;
                end else if (!stall_i) begin
                    pc_d    = pc_q + PC_INCREMENT;
                    state_d = S_REQ;
                end
            end
            S_FLUSH: begin
                if (if_ack_i) begin
                    pc_d    = redirect_c ? target_c : pending_q;
                    state_d = S_REQ;
                end else if (redirect_c) begin
                    pending_d = target_c;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, PC and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            pc_q      <= BOOT_ADDR;
            pending_q <= '0;
            if_req_o  <= 1'b0;
            if_addr_o <= BOOT_ADDR;
            instr_o   <= '0;
            pc_o      <= '0;
            valid_o   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            if_req_o  <= (state_d == S_REQ) || (state_d == S_FLUSH);
            if_addr_o <= pc_d;
            instr_o   <= instr_d;
            pc_o      <= pc_out_d;
            valid_o   <= (state_d == S_OUT);
        end
    end

endmodule
